// File: rtl/fft_peak_search.sv
// Streaming peak search over one 256-point FFT frame: L1 magnitude per bin, peak/second/bin and sum,
// one result per frame on a valid/ready port.
module fft_peak_search #(
  parameter int FFT_SIZE = 256,
  parameter int DATA_W   = 18,
  localparam int BIN_W   = $clog2(FFT_SIZE),
  localparam int MAG_W   = DATA_W + 1,
  localparam int SUM_W   = MAG_W + BIN_W
) (
  input  logic             CLK,
  input  logic             NGRST,
  input  logic             ENABLE,
  input  logic             OUTP_READY,
  output logic             READ_OUTP,
  input  logic             DATAO_VALID,
  input  logic [31:0]      DATAO_RE,
  input  logic [31:0]      DATAO_IM,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [BIN_W-1:0] PEAK_BIN,
  output logic [MAG_W-1:0] PEAK_MAG,
  output logic [MAG_W-1:0] SECOND_MAG,
  output logic [SUM_W-1:0] MAG_SUM,
  output logic             ERR_UNEXP,
  output logic [1:0]       DBG_STATE
);

  // Result handshake: RES_VALID rises with stable fields and holds them until a cycle with
  // RES_VALID & RES_READY; it drops on the following cycle and never depends on RES_READY.
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               read_outp_q, read_outp_d;
  logic               res_valid_q, res_valid_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   cnt_q, cnt_d;
  logic               s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [BIN_W-1:0]   s1_idx_q, s1_idx_d;
  logic [DATA_W-1:0]  s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic               s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [BIN_W-1:0]   s2_idx_q, s2_idx_d;
  logic [MAG_W-1:0]   s2_mag_q, s2_mag_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [MAG_W-1:0]   peak_q, peak_d, second_q, second_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               unused_hi;

  assign unused_hi = ^{DATAO_RE[31:DATA_W], DATAO_IM[31:DATA_W]};

  // |-2^(DATA_W-1)| fits exactly once the result is read as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    abs_val = x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

  always_comb begin
    state_d     = state_q;
    read_outp_d = 1'b0;
    res_valid_d = res_valid_q;
    err_d       = err_q | (DATAO_VALID && (state_q != COLLECT));
    cnt_d       = cnt_q;
    s1_vld_d    = 1'b0;
    s1_last_d   = s1_last_q;
    s1_idx_d    = s1_idx_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    s2_vld_d    = s1_vld_q;
    s2_last_d   = s1_last_q;
    s2_idx_d    = s1_idx_q;
    s2_mag_d    = {1'b0, s1_re_q} + {1'b0, s1_im_q};
    bin_d       = bin_q;
    peak_d      = peak_q;
    second_d    = second_q;
    sum_d       = sum_q;

    if (s2_vld_q) begin
      sum_d = sum_q + SUM_W'(s2_mag_q);
      if (s2_mag_q > peak_q) begin
        second_d = peak_q;
        peak_d   = s2_mag_q;
        bin_d    = s2_idx_q;
      end else if (s2_mag_q > second_q) begin
        second_d = s2_mag_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (ENABLE && OUTP_READY) begin
          read_outp_d = 1'b1;
          cnt_d       = '0;
          bin_d       = '0;
          peak_d      = '0;
          second_d    = '0;
          sum_d       = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (DATAO_VALID) begin
          s1_vld_d  = 1'b1;
          s1_last_d = (cnt_q == BIN_W'(FFT_SIZE - 1));
          s1_idx_d  = cnt_q;
          s1_re_d   = abs_val(DATAO_RE[DATA_W-1:0]);
          s1_im_d   = abs_val(DATAO_IM[DATA_W-1:0]);
          cnt_d     = cnt_q + BIN_W'(1);
          if (cnt_q == BIN_W'(FFT_SIZE - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (s2_vld_q && s2_last_q) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q     <= IDLE;
      read_outp_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_idx_q    <= '0;
      s2_mag_q    <= '0;
      bin_q       <= '0;
      peak_q      <= '0;
      second_q    <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      read_outp_q <= read_outp_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_idx_q    <= s1_idx_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s2_vld_q    <= s2_vld_d;
      s2_last_q   <= s2_last_d;
      s2_idx_q    <= s2_idx_d;
      s2_mag_q    <= s2_mag_d;
      bin_q       <= bin_d;
      peak_q      <= peak_d;
      second_q    <= second_d;
      sum_q       <= sum_d;
    end
  end

  assign READ_OUTP  = read_outp_q;
  assign RES_VALID  = res_valid_q;
  assign PEAK_BIN   = bin_q;
  assign PEAK_MAG   = peak_q;
  assign SECOND_MAG = second_q;
  assign MAG_SUM    = sum_q;
  assign ERR_UNEXP  = err_q;
  assign DBG_STATE  = state_q;

endmodule
